// File: rtl/bus_control_sequencer.sv
// Timing-and-control sequencer for the 16-bit common-bus datapath.
// Steps fetch/decode/indirect/execute micro-ops and drives registered bus controls.
module bus_control_sequencer #(
    parameter int STEP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       ir_i,
    input  logic [2:0] ir_op,
    input  logic       dr_zero,
    output logic [2:0] select,
    output logic [5:0] LD,
    output logic [4:0] INR,
    output logic [4:0] CLR,
    output logic       read,
    output logic       write,
    output logic       busy,
    output logic       halted,
    output logic       instr_done,
    output logic [3:0] state_dbg
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(STEP_CYCLES - 1);

    localparam logic [2:0] OP_LDA = 3'd0;
    localparam logic [2:0] OP_BUN = 3'd1;
    localparam logic [2:0] OP_ISZ = 3'd2;
    localparam logic [2:0] OP_CLA = 3'd3;
    localparam logic [2:0] OP_INC = 3'd4;
    localparam logic [2:0] OP_ATT = 3'd5;
    localparam logic [2:0] OP_TTA = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    localparam logic [2:0] SEL_ZERO = 3'b000;
    localparam logic [2:0] SEL_AR   = 3'b001;
    localparam logic [2:0] SEL_PC   = 3'b010;
    localparam logic [2:0] SEL_DR   = 3'b011;
    localparam logic [2:0] SEL_AC   = 3'b100;
    localparam logic [2:0] SEL_IR   = 3'b101;
    localparam logic [2:0] SEL_TR   = 3'b110;
    localparam logic [2:0] SEL_MEM  = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH0   = 4'd1,
        S_FETCH1   = 4'd2,
        S_DECODE   = 4'd3,
        S_INDIRECT = 4'd4,
        S_EXEC0    = 4'd5,
        S_EXEC1    = 4'd6,
        S_EXEC2    = 4'd7,
        S_EXEC3    = 4'd8,
        S_HALT     = 4'd9
    } state_t;

    state_t          state_q, state_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [2:0]      op_q, op_n;
    logic            dz_q, dz_n;
    logic            step_last;

    logic [2:0]      sel_d;
    logic [5:0]      ld_d;
    logic [4:0]      inr_d;
    logic [4:0]      clr_d;
    logic            rd_d;
    logic            done_d;
    logic            busy_d;
    logic            halted_d;
    logic            fin;

    assign step_last = (cnt_q == LAST_CNT);
    assign state_dbg = state_q;
    // The datapath has no path from a register to memory data, so stores never happen.
    assign write     = 1'b0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            op_q    <= op_n;
            dz_q    <= dz_n;
        end
    end

    // Next step: start only matters while parked; busy states advance on the step's last clock.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        op_n    = op_q;
        dz_n    = dz_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_n = S_FETCH0;
                    cnt_n   = '0;
                end
            end
            default: begin
                if (!step_last) begin
                    cnt_n = cnt_q + 1'b1;
                end else begin
                    cnt_n = '0;
                    case (state_q)
                        S_FETCH0:   state_n = S_FETCH1;
                        S_FETCH1:   state_n = S_DECODE;
                        S_DECODE: begin
                            op_n    = ir_op;
                            state_n = ir_i ? S_INDIRECT : S_EXEC0;
                        end
                        S_INDIRECT: state_n = S_EXEC0;
                        S_EXEC0: begin
                            if (op_q == OP_LDA || op_q == OP_ISZ) begin
                                state_n = S_EXEC1;
                            end else if (op_q == OP_HLT) begin
                                state_n = S_HALT;
                            end else begin
                                state_n = S_FETCH0;
                            end
                        end
                        S_EXEC1:    state_n = (op_q == OP_ISZ) ? S_EXEC2 : S_FETCH0;
                        S_EXEC2: begin
                            dz_n    = dr_zero;
                            state_n = S_EXEC3;
                        end
                        S_EXEC3:    state_n = S_FETCH0;
                        default:    state_n = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    // Outputs are decoded from the upcoming step so that the registers present them in-step.
    always_comb begin
        fin      = (cnt_n == LAST_CNT);
        sel_d    = SEL_ZERO;
        rd_d     = 1'b0;
        ld_d     = '0;
        inr_d    = '0;
        clr_d    = '0;
        done_d   = 1'b0;
        busy_d   = (state_n != S_IDLE) && (state_n != S_HALT);
        halted_d = (state_n == S_HALT);
        case (state_n)
            S_FETCH0: begin
                sel_d    = SEL_PC;
                ld_d[0]  = fin;
            end
            S_FETCH1: begin
                sel_d    = SEL_MEM;
                rd_d     = 1'b1;
                ld_d[4]  = fin;
                inr_d[1] = fin;
            end
            S_DECODE: begin
                sel_d    = SEL_IR;
                ld_d[0]  = fin;
            end
            S_INDIRECT: begin
                sel_d    = SEL_MEM;
                rd_d     = 1'b1;
                ld_d[0]  = fin;
            end
            S_EXEC0: begin
                case (op_n)
                    OP_LDA, OP_ISZ: begin
                        sel_d   = SEL_MEM;
                        rd_d    = 1'b1;
                        ld_d[2] = fin;
                    end
                    OP_BUN: begin
                        sel_d   = SEL_AR;
                        ld_d[1] = fin;
                        done_d  = fin;
                    end
                    OP_CLA: begin
                        clr_d[3] = fin;
                        done_d   = fin;
                    end
                    OP_INC: begin
                        inr_d[3] = fin;
                        done_d   = fin;
                    end
                    OP_ATT: begin
                        sel_d   = SEL_AC;
                        ld_d[5] = fin;
                        done_d  = fin;
                    end
                    OP_TTA: begin
                        sel_d   = SEL_TR;
                        ld_d[3] = fin;
                        done_d  = fin;
                    end
                    default: begin
                        done_d = fin;
                    end
                endcase
            end
            S_EXEC1: begin
                if (op_n == OP_LDA) begin
                    sel_d   = SEL_DR;
                    ld_d[3] = fin;
                    done_d  = fin;
                end else begin
                    inr_d[2] = fin;
                end
            end
            S_EXEC3: begin
                // Skip-on-zero: PC advances only when DR was zero after the increment.
                inr_d[1] = fin & dz_n;
                done_d   = fin;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            select     <= '0;
            LD         <= '0;
            INR        <= '0;
            CLR        <= '0;
            read       <= 1'b0;
            busy       <= 1'b0;
            halted     <= 1'b0;
            instr_done <= 1'b0;
        end else begin
            select     <= sel_d;
            LD         <= ld_d;
            INR        <= inr_d;
            CLR        <= clr_d;
            read       <= rd_d;
            busy       <= busy_d;
            halted     <= halted_d;
            instr_done <= done_d;
        end
    end

endmodule

// File: tb/tb_bus_control_sequencer.sv
// Random instruction streams against a step-list reference model for two STEP_CYCLES settings.
// Expected per-clock control words are queued by the driver and popped by monitors.
module tb_bus_control_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n, start_a, start_b, ir_i, dr_zero;
    logic [2:0] ir_op;

    logic [2:0] sel_a, sel_b;
    logic [5:0] ld_a, ld_b;
    logic [4:0] inr_a, inr_b, clr_a, clr_b;
    logic       read_a, read_b, write_a, write_b, busy_a, busy_b;
    logic       halted_a, halted_b, done_a, done_b;
    logic [3:0] dbg_a, dbg_b;

    bus_control_sequencer #(.STEP_CYCLES(2)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a), .ir_i(ir_i), .ir_op(ir_op),
        .dr_zero(dr_zero), .select(sel_a), .LD(ld_a), .INR(inr_a), .CLR(clr_a),
        .read(read_a), .write(write_a), .busy(busy_a), .halted(halted_a),
        .instr_done(done_a), .state_dbg(dbg_a)
    );

    bus_control_sequencer #(.STEP_CYCLES(1)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b), .ir_i(ir_i), .ir_op(ir_op),
        .dr_zero(dr_zero), .select(sel_b), .LD(ld_b), .INR(inr_b), .CLR(clr_b),
        .read(read_b), .write(write_b), .busy(busy_b), .halted(halted_b),
        .instr_done(done_b), .state_dbg(dbg_b)
    );

    // Control word: {select, read, write, LD, INR, CLR, instr_done}
    logic [21:0] ctl_a, ctl_b;
    assign ctl_a = {sel_a, read_a, write_a, ld_a, inr_a, clr_a, done_a};
    assign ctl_b = {sel_b, read_b, write_b, ld_b, inr_b, clr_b, done_b};

    typedef struct packed {
        logic [2:0] sel;
        logic       rd;
        logic [5:0] ld;
        logic [4:0] inr;
        logic [4:0] clr;
    } step_t;

    logic [21:0] exp_q_a[$];
    logic [21:0] exp_q_b[$];
    step_t       steps_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cur_sc = 2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic step_t mk(input logic [2:0] sel, input logic rd, input logic [5:0] ld,
                                 input logic [4:0] inr, input logic [4:0] clr);
        step_t s;
        s.sel = sel; s.rd = rd; s.ld = ld; s.inr = inr; s.clr = clr;
        return s;
    endfunction

    // Micro-op list of one instruction, straight from the instruction table.
    task automatic build(input logic ind, input logic [2:0] op, input logic dz);
        steps_q.delete();
        steps_q.push_back(mk(3'b010, 1'b0, 6'b000001, 5'b00000, 5'b00000));
        steps_q.push_back(mk(3'b111, 1'b1, 6'b010000, 5'b00010, 5'b00000));
        steps_q.push_back(mk(3'b101, 1'b0, 6'b000001, 5'b00000, 5'b00000));
        if (ind) steps_q.push_back(mk(3'b111, 1'b1, 6'b000001, 5'b00000, 5'b00000));
        case (op)
            3'd0: begin
                steps_q.push_back(mk(3'b111, 1'b1, 6'b000100, 5'b00000, 5'b00000));
                steps_q.push_back(mk(3'b011, 1'b0, 6'b001000, 5'b00000, 5'b00000));
            end
            3'd1: steps_q.push_back(mk(3'b001, 1'b0, 6'b000010, 5'b00000, 5'b00000));
            3'd2: begin
                steps_q.push_back(mk(3'b111, 1'b1, 6'b000100, 5'b00000, 5'b00000));
                steps_q.push_back(mk(3'b000, 1'b0, 6'b000000, 5'b00100, 5'b00000));
                steps_q.push_back(mk(3'b000, 1'b0, 6'b000000, 5'b00000, 5'b00000));
                steps_q.push_back(mk(3'b000, 1'b0, 6'b000000, dz ? 5'b00010 : 5'b00000, 5'b00000));
            end
            3'd3: steps_q.push_back(mk(3'b000, 1'b0, 6'b000000, 5'b00000, 5'b01000));
            3'd4: steps_q.push_back(mk(3'b000, 1'b0, 6'b000000, 5'b01000, 5'b00000));
            3'd5: steps_q.push_back(mk(3'b100, 1'b0, 6'b100000, 5'b00000, 5'b00000));
            3'd6: steps_q.push_back(mk(3'b110, 1'b0, 6'b001000, 5'b00000, 5'b00000));
            default: steps_q.push_back(mk(3'b000, 1'b0, 6'b000000, 5'b00000, 5'b00000));
        endcase
    endtask

    task automatic set_start(input logic v);
        if (cur_sc == 2) start_a = v;
        else start_b = v;
    endtask

    // Issue one instruction; queue its per-clock expectations; optionally poke start mid-flight.
    task automatic run_instr(input bit first, input logic ind, input logic [2:0] op, input logic dz);
        int len;
        int poke;
        logic [21:0] w;
        logic fin;
        build(ind, op, dz);
        for (int i = 0; i < steps_q.size(); i++) begin
            for (int c = 0; c < cur_sc; c++) begin
                fin = (c == cur_sc - 1);
                w = {steps_q[i].sel, steps_q[i].rd, 1'b0,
                     fin ? steps_q[i].ld : 6'b0, fin ? steps_q[i].inr : 5'b0,
                     fin ? steps_q[i].clr : 5'b0, fin && (i == steps_q.size() - 1)};
                if (cur_sc == 2) exp_q_a.push_back(w);
                else exp_q_b.push_back(w);
            end
        end
        len = steps_q.size() * cur_sc;
        poke = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len - 1)) : -1;
        ir_i = ind; ir_op = op; dr_zero = dz;
        for (int c = 0; c < len; c++) begin
            set_start((first && c == 0) || (c == poke));
            @(posedge clock); #1;
        end
        set_start(1'b0);
        if (op == 3'd7) begin
            @(posedge clock); #1;
            if (cur_sc == 2) check("halt_a", {halted_a, busy_a}, 2'b10);
            else check("halt_b", {halted_b, busy_b}, 2'b10);
        end
    endtask

    task automatic run_random(input int n);
        for (int k = 0; k < n; k++) begin
            run_instr(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (busy_a) begin
                if (exp_q_a.size() == 0) check("mon_a_extra", {ctl_a, halted_a}, 23'h7fffff);
                else check("mon_a", {ctl_a, halted_a}, {exp_q_a.pop_front(), 1'b0});
            end else begin
                check("idle_a", ctl_a, 22'h0);
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            if (busy_b) begin
                if (exp_q_b.size() == 0) check("mon_b_extra", {ctl_b, halted_b}, 23'h7fffff);
                else check("mon_b", {ctl_b, halted_b}, {exp_q_b.pop_front(), 1'b0});
            end else begin
                check("idle_b", ctl_b, 22'h0);
            end
        end
    end

    initial begin
        #400000;
        n_vec++; n_err++;
        $display("FAIL timeout: got running expected finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        ir_i = 1'b0; ir_op = 3'd0; dr_zero = 1'b0;
        repeat (3) @(posedge clock); #1;
        check("rst_a", {ctl_a, busy_a, halted_a}, 24'h0);
        check("rst_b", {ctl_b, busy_b, halted_b}, 24'h0);
        @(negedge clock) reset_n = 1'b1;
        repeat (3) @(posedge clock); #1;
        check("no_start_a", {busy_a, halted_a}, 2'b00);

        // Abort in the middle of FETCH1: outputs must drop without waiting for a clock.
        build(1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp_q_a.push_back({steps_q[0].sel, 2'b00, i == 1 ? steps_q[0].ld : 6'b0, 11'b0});
        end
        start_a = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        repeat (2) @(posedge clock); #1;
        check("fetch1_read", {sel_a, read_a, busy_a}, 5'b11111);
        reset_n = 1'b0;
        #1;
        check("abort_out", {ctl_a, busy_a, halted_a}, 24'h0);
        exp_q_a.delete();
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        repeat (4) @(posedge clock); #1;
        check("post_abort", {busy_a, halted_a}, 2'b00);

        // STEP_CYCLES=2: directed table, then random stream, halt, restart.
        cur_sc = 2;
        run_instr(1'b1, 1'b0, 3'd0, 1'b0);
        run_instr(1'b0, 1'b1, 3'd1, 1'b0);
        run_instr(1'b0, 1'b0, 3'd2, 1'b1);
        run_instr(1'b0, 1'b0, 3'd2, 1'b0);
        run_instr(1'b0, 1'b1, 3'd2, 1'b1);
        run_random(24);
        run_instr(1'b0, 1'($urandom_range(0, 1)), 3'd7, 1'b0);
        repeat (3) @(posedge clock); #1;
        check("halt_hold_a", {halted_a, busy_a}, 2'b10);
        run_instr(1'b1, 1'b0, 3'd5, 1'b0);
        run_random(8);
        run_instr(1'b0, 1'b0, 3'd7, 1'b0);

        // STEP_CYCLES=1
        cur_sc = 1;
        run_instr(1'b1, 1'b0, 3'd0, 1'b0);
        run_instr(1'b0, 1'b0, 3'd2, 1'b1);
        run_random(12);
        run_instr(1'b0, 1'b1, 3'd7, 1'b0);

        repeat (4) @(posedge clock); #1;
        check("drain_a", exp_q_a.size(), 0);
        check("drain_b", exp_q_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_control_sequencer.md
Name: bus_control_sequencer

Overview:
Timing-and-control unit for the 16-bit common-bus datapath (AR/PC/DR/AC/IR/TR, 4096x16 memory). It runs a fetch / decode / indirect / execute micro-operation sequence for a small instruction set. Each step drives the datapath's select, LD, INR, CLR, read and write controls. It sits directly beside the datapath, and its outputs connect one-to-one to the identically named datapath inputs.

Parameters:
STEP_CYCLES, 2, clocks per micro-op step (min 1); covers the datapath's registered-bus latency.

Ports:
clock  in  1  system clock; sequencer advances on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-clock pulse; begins or resumes execution; honoured only in IDLE or HALT
ir_i  in  1  IR[15], indirect bit
ir_op  in  3  IR[14:12], opcode
dr_zero  in  1  high when DR == 0
select  out  3  bus source (000 zero, 001 AR, 010 PC, 011 DR, 100 AC, 101 IR, 110 TR, 111 memory data)
LD  out  6  load enables [0]AR [1]PC [2]DR [3]AC [4]IR [5]TR
INR  out  5  increment enables [0]AR [1]PC [2]DR [3]AC [4]TR
CLR  out  5  clear enables, same mapping as INR
read  out  1  memory read
write  out  1  memory write; tied 0, because the datapath cannot source store data
busy  out  1  high in any state other than IDLE and HALT
halted  out  1  high in HALT
instr_done  out  1  one-clock pulse on the final clock of an instruction's last step

Behaviour:
- Reset (async, reset_n=0): state=IDLE, step counter=0, latched opcode and flags cleared. All outputs 0.
- Release of reset is synchronised; the first state change happens on the first rising edge with reset_n=1 and start=1.
- All outputs are registered.
- A step lasts exactly STEP_CYCLES clocks.
  - select and read are held for every clock of the step.
  - LD, INR and CLR assert only on the step's final clock.
  - Every output not listed for a step is 0.
- States and steps:
  - IDLE: outputs 0. start -> FETCH0.
  - FETCH0: select=010, LD[0] (AR<-PC). -> FETCH1.
  - FETCH1: select=111, read, LD[4] (IR<-M), INR[1] (PC++). -> DECODE.
  - DECODE: select=101, LD[0] (AR<-IR[11:0]).
    - ir_i and ir_op are latched on the final clock of this step.
    - ir_i=1 -> INDIRECT; ir_i=0 -> EXEC0.
  - INDIRECT: select=111, read, LD[0] (AR<-M). -> EXEC0.
- Execute by latched opcode. The last step listed is the terminal step; after it the sequencer returns to FETCH0.
  - 000 LDA:
    - EXEC0: select=111, read, LD[2].
    - EXEC1: select=011, LD[3].
  - 001 BUN:
    - EXEC0: select=001, LD[1] (PC<-AR).
  - 010 ISZ:
    - EXEC0: select=111, read, LD[2].
    - EXEC1: INR[2].
    - EXEC2: no controls; dr_zero is sampled on its final clock.
    - EXEC3: INR[1] only if the sampled dr_zero=1; otherwise no controls. The step is taken in both cases.
  - 011 CLA: EXEC0: CLR[3].
  - 100 INC: EXEC0: INR[3].
  - 101 ATT: EXEC0: select=100, LD[5] (TR<-AC).
  - 110 TTA: EXEC0: select=110, LD[3] (AC<-TR).
  - 111 HLT: EXEC0 has no controls; afterwards -> HALT instead of FETCH0.
- Reaching HALT: busy drops and halted rises on the first clock of HALT.
- instr_done pulses on the final clock of the terminal step, HLT included.
- HALT: outputs 0. start -> FETCH0 at the current PC. PC is never cleared by this block.
- start while busy is ignored, with no effect on the sequence.
- Addressing: the AR load from IR or memory truncates to 12 bits inside the datapath; the sequencer performs no arithmetic on the address.
- Reset asserted mid-step aborts immediately; all outputs go to 0 asynchronously.
- STEP_CYCLES=1: every control is asserted for one clock per step. Step counts are unchanged.
- Instruction length in steps:
  - LDA direct 5, indirect 6
  - BUN, CLA, INC, ATT, TTA, HLT 4 (+1 if indirect)
  - ISZ 7 (+1 if indirect)

Test Plan:
1. Reset mid-FETCH1: reset_n=0 during read=1 -> all outputs 0 and busy=0 in the same cycle. After release, no activity until start.
2. STEP_CYCLES=2, ir_i=0, ir_op=000, start pulse -> select/LD sequence 010/LD[0], 111+read/LD[4]+INR[1], 101/LD[0], 111+read/LD[2], 011/LD[3]. Each control is held 2 clocks; LD/INR assert on the second clock only. instr_done fires on clock 10; clock 11 is FETCH0.
3. ir_i=1, ir_op=001 -> an INDIRECT step (select=111, read, LD[0]) precedes EXEC0 (select=001, LD[1]); instr_done on clock 10.
4. ISZ with dr_zero=1 sampled in EXEC2 -> INR[1]=1 on the final clock of EXEC3. Repeat with dr_zero=0 -> INR all 0 in EXEC3; instr_done still fires on clock 14.
5. ir_op=111 -> halted=1 and busy=0 after instr_done. A start pulse issued while busy, before the HLT, is ignored. start in HALT -> FETCH0 (select=010, LD[0]).
6. STEP_CYCLES=1, LDA direct -> 5 clocks start-to-instr_done. Each LD bit is high for exactly 1 clock. write stays 0 throughout all tests.
